// File: rtl/ab_encoder.sv
// rtl/ab_encoder.sv - A/B vernier edge counts to pulse-width code W = A*PB - B*PA
// Shift-add multiply over WA cycles, one subtract/saturate cycle, one-cycle done pulse.
module ab_encoder #(
    parameter int WA = 7,
    parameter int WW = 13,
    parameter int PA = 80,
    parameter int PB = 81
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          start,
    input  logic [WA-1:0] A_val,
    input  logic [WA-1:0] B_val,
    output logic [WW-1:0] W,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int AW = WA + 7;
    localparam int DW = WA + 8;
    localparam int IW = $clog2(WA + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_SUB  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [AW-1:0] PA_W  = AW'(PA);
    localparam logic [AW-1:0] PB_W  = AW'(PB);
    localparam logic [AW-1:0] W_MAX = AW'((2 ** WW) - 1);
    localparam logic [IW-1:0] I_LAST = IW'(WA - 1);

    logic [1:0]    state_q, state_d;
    logic [WA-1:0] a_q, a_d, b_q, b_d;
    logic [AW-1:0] pa_q, pa_d, pb_q, pb_d;
    logic [IW-1:0] i_q, i_d;
    logic [WW-1:0] w_q, w_d;
    logic          err_q, err_d;
    logic [DW-1:0] diff;

    // Zero-extended subtract; the top bit is the sign of pA - pB.
    assign diff = {1'b0, pa_q} - {1'b0, pb_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        i_d     = i_q;
        w_d     = w_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A_val;
                    b_d     = B_val;
                    pa_d    = '0;
                    pb_d    = '0;
                    i_d     = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (a_q[i_q]) pa_d = pa_q + (PB_W << i_q);
                if (b_q[i_q]) pb_d = pb_q + (PA_W << i_q);
                i_d = i_q + 1'b1;
                if (i_q == I_LAST) state_d = S_SUB;
            end
            S_SUB: begin
                if (diff[DW-1]) begin
                    w_d   = '0;
                    err_d = 1'b1;
                end else if (diff[AW-1:0] > W_MAX) begin
                    w_d   = '1;
                    err_d = 1'b1;
                end else begin
                    w_d   = diff[WW-1:0];
                    err_d = 1'b0;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
            i_q     <= '0;
            w_q     <= '0;
            err_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            i_q     <= i_d;
            w_q     <= w_d;
            err_q   <= err_d;
        end
    end

    assign W    = w_q;
    assign err  = err_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule
